conv2d_stream_engine: RTL and testbench

- Parametrised successor to the fixed 28x28 / 3x3 convolution block.
- Captures a flat input feature map and a square kernel on a start request, then computes one valid-mode output pixel per clock with a configurable stride.
- Each output pixel is streamed out and also accumulated into a flat output map.
- Adds signed/unsigned arithmetic, optional ReLU, accumulator saturation and a busy/done handshake.
- Sits between the feature-map buffer and the pooling/dense stages of the CNN datapath.

---
 rtl/conv2d_stream_engine.sv | 204 ++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_engine.sv
// Valid-mode 2-D convolution over a captured feature map and kernel,
// streaming one saturated output pixel per clock in raster order.
//
// state  | meaning
// S_IDLE | waiting for en; outputs hold, o_valid low
// S_RUN  | one output pixel computed and written per clock
// S_DONE | map complete; done held until en drops
module conv2d_stream_engine #(
  parameter int IMG_SIZE = 28,
  parameter int WIN_SIZE = 3,
  parameter int STRIDE   = 1,
  parameter int ELEM_W   = 8,
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 0,
  localparam int OUT_SIZE = (IMG_SIZE - WIN_SIZE) / STRIDE + 1,
  localparam int CW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                relu_en,
  input  logic [IMG_SIZE*IMG_SIZE*ELEM_W-1:0] i_featuremap,
  input  logic [WIN_SIZE*WIN_SIZE*ELEM_W-1:0] kernel,
  output logic [OUT_SIZE*OUT_SIZE*ACC_W-1:0]  o_featuremap,
  output logic [ACC_W-1:0]                    o_pixel,
  output logic                                o_valid,
  output logic [CW-1:0]                       o_row,
  output logic [CW-1:0]                       o_col,
  output logic                                busy,
  output logic                                done
);

  localparam int  NK       = WIN_SIZE * WIN_SIZE;
  localparam int  SUM_W    = 2 * ELEM_W + $clog2(NK) + 1;
  localparam int  SAT_W    = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
  localparam int  IMG_BITS = IMG_SIZE * IMG_SIZE * ELEM_W;
  localparam int  KER_BITS = NK * ELEM_W;
  localparam int  OUT_BITS = OUT_SIZE * OUT_SIZE * ACC_W;
  localparam int  IW       = $clog2(IMG_BITS);
  localparam int  KW       = $clog2(KER_BITS);
  localparam int  OW       = $clog2(OUT_BITS);
  localparam bit  SGN      = (SIGNED != 0);
  localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

  localparam logic signed [SAT_W-1:0] U_MAX = {{(SAT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic signed [SAT_W-1:0] S_MAX = {{(SAT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] S_MIN = {{(SAT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IMG_BITS-1:0]   img_q, img_d;
  logic [KER_BITS-1:0]   ker_q, ker_d;
  logic                  relu_q, relu_d;
  logic [OUT_BITS-1:0]   fmap_q, fmap_d;
  logic [CW-1:0]         row_q, row_d, col_q, col_d;
  logic [CW-1:0]         prow_q, prow_d, pcol_q, pcol_d;
  logic [ACC_W-1:0]      pix_q, pix_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [IW-1:0]              a_idx;
  logic [KW-1:0]              k_idx;
  logic [OW-1:0]              f_idx;
  logic [ELEM_W-1:0]          a_raw, k_raw;
  logic signed [SUM_W-1:0]    a_ext, k_ext, sum;
  logic signed [SAT_W-1:0]    sum_w, sat;
  logic [ACC_W-1:0]           pix;

  // Operands are widened to the full sum width first so the signed product's
  // low bits are exact and the unsigned sum never reaches the sign bit.
  always_comb begin
    sum   = '0;
    a_idx = '0;
    k_idx = '0;
    a_raw = '0;
    k_raw = '0;
    a_ext = '0;
    k_ext = '0;
    for (int i = 0; i < WIN_SIZE; i++) begin
      for (int j = 0; j < WIN_SIZE; j++) begin
        a_idx = IW'(((int'(row_q) * STRIDE + i) * IMG_SIZE + int'(col_q) * STRIDE + j) * ELEM_W);
        k_idx = KW'((i * WIN_SIZE + j) * ELEM_W);
        a_raw = img_q[a_idx +: ELEM_W];
        k_raw = ker_q[k_idx +: ELEM_W];
        a_ext = {{(SUM_W-ELEM_W){a_raw[ELEM_W-1] & SGN}}, a_raw};
        k_ext = {{(SUM_W-ELEM_W){k_raw[ELEM_W-1] & SGN}}, k_raw};
        sum   = sum + a_ext * k_ext;
      end
    end
  end

  always_comb begin
    sum_w = {{(SAT_W-SUM_W){sum[SUM_W-1]}}, sum};
    sat   = sum_w;
    if (SGN) begin
      if (sum_w > S_MAX)      sat = S_MAX;
      else if (sum_w < S_MIN) sat = S_MIN;
      if (relu_q && sat[SAT_W-1]) sat = '0;
    end else if (sum_w > U_MAX) begin
      sat = U_MAX;
    end
    pix = sat[ACC_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    ker_d   = ker_q;
    relu_d  = relu_q;
    fmap_d  = fmap_q;
    row_d   = row_q;
    col_d   = col_q;
    prow_d  = prow_q;
    pcol_d  = pcol_q;
    pix_d   = pix_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    f_idx   = OW'((int'(row_q) * OUT_SIZE + int'(col_q)) * ACC_W);
    case (state_q)
      S_IDLE: begin
        if (en) begin
          img_d   = i_featuremap;
          ker_d   = kernel;
          relu_d  = relu_en;
          fmap_d  = '0;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        valid_d               = 1'b1;
        pix_d                 = pix;
        prow_d                = row_q;
        pcol_d                = col_q;
        fmap_d[f_idx +: ACC_W] = pix;
        if (col_q == LAST) begin
          col_d = '0;
          if (row_q == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            row_d = row_q + CW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DONE: begin
        if (!en) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      img_q   <= '0;
      ker_q   <= '0;
      relu_q  <= 1'b0;
      fmap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      prow_q  <= '0;
      pcol_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      ker_q   <= ker_d;
      relu_q  <= relu_d;
      fmap_q  <= fmap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      prow_q  <= prow_d;
      pcol_q  <= pcol_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_featuremap = fmap_q;
  assign o_pixel      = pix_q;
  assign o_valid      = valid_q;
  assign o_row        = prow_q;
  assign o_col        = pcol_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench: a default unsigned engine and a small signed, strided,
// narrow-accumulator engine, both checked against a plain arithmetic model.
module tb_conv2d_stream_engine;

  localparam int A_IMG = 28, A_OS = 26, A_N = 676, A_ACC = 20;
  localparam int B_IMG = 8,  B_OS = 3,  B_N = 9,   B_ACC = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                       en_a, relu_a, en_b, relu_b;
  logic [A_IMG*A_IMG*8-1:0]   ifm_a;
  logic [B_IMG*B_IMG*8-1:0]   ifm_b;
  logic [71:0]                kv_a, kv_b;
  logic [A_OS*A_OS*A_ACC-1:0] ofm_a;
  logic [B_OS*B_OS*B_ACC-1:0] ofm_b;
  logic [A_ACC-1:0]           pix_a;
  logic [B_ACC-1:0]           pix_b;
  logic                       valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [4:0]                 row_a, col_a;
  logic [1:0]                 row_b, col_b;

  conv2d_stream_engine dut_a (
    .clk(clk), .rst(rst_n), .en(en_a), .relu_en(relu_a),
    .i_featuremap(ifm_a), .kernel(kv_a), .o_featuremap(ofm_a),
    .o_pixel(pix_a), .o_valid(valid_a), .o_row(row_a), .o_col(col_a),
    .busy(busy_a), .done(done_a)
  );

  conv2d_stream_engine #(
    .IMG_SIZE(B_IMG), .WIN_SIZE(3), .STRIDE(2), .ELEM_W(8), .ACC_W(B_ACC), .SIGNED(1)
  ) dut_b (
    .clk(clk), .rst(rst_n), .en(en_b), .relu_en(relu_b),
    .i_featuremap(ifm_b), .kernel(kv_b), .o_featuremap(ofm_b),
    .o_pixel(pix_b), .o_valid(valid_b), .o_row(row_b), .o_col(col_b),
    .busy(busy_b), .done(done_b)
  );

  typedef struct {int row; int col; longint pix;} exp_t;
  typedef longint lq_t[$];

  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   q_a[$], q_b[$];
  int     img_a[$], ker_a[$], img_b[$], ker_b[$];
  longint exp_a[$], exp_b[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Reference: direct window sums with integer arithmetic, clamped to the
  // accumulator range, ReLU on signed maps; 3x3 window, 8-bit elements.
  function automatic lq_t model_map(input int img[$], input int ker[$], input int isz,
                                    input int st, input bit sgn, input int accw, input bit relu);
    lq_t    res;
    int     osz = (isz - 3) / st + 1;
    longint s, a, k, hi, lo;
    hi = sgn ? (longint'(1) << (accw - 1)) - 1 : (longint'(1) << accw) - 1;
    lo = sgn ? -(longint'(1) << (accw - 1)) : 0;
    for (int r = 0; r < osz; r++) begin
      for (int c = 0; c < osz; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            a = img[(r * st + i) * isz + c * st + j];
            k = ker[i * 3 + j];
            if (sgn && a > 127) a -= 256;
            if (sgn && k > 127) k -= 256;
            s += a * k;
          end
        end
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (sgn && relu && s < 0) s = 0;
        res.push_back(s & ((longint'(1) << accw) - 1));
      end
    end
    return res;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid_a) begin
      if (q_a.size() == 0) check("a_spurious_valid", 64'd1, 64'd0);
      else begin
        e = q_a.pop_front();
        check("a_pixel", 64'(pix_a), 64'(e.pix));
        check("a_row", 64'(row_a), 64'(e.row));
        check("a_col", 64'(col_a), 64'(e.col));
      end
    end
    if (valid_b) begin
      if (q_b.size() == 0) check("b_spurious_valid", 64'd1, 64'd0);
      else begin
        e = q_b.pop_front();
        check("b_pixel", 64'(pix_b), 64'(e.pix));
        check("b_row", 64'(row_b), 64'(e.row));
        check("b_col", 64'(col_b), 64'(e.col));
      end
    end
  end

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_done"}, 64'(done_a), 64'd0);
    check({tag, "_valid"}, 64'(valid_a), 64'd0);
    check({tag, "_fmap"}, 64'(|ofm_a), 64'd0);
    check({tag, "_pixel"}, 64'(pix_a), 64'd0);
  endtask

  task automatic run_a(input bit relu, input int abort_at);
    for (int i = 0; i < A_IMG * A_IMG; i++) ifm_a[i*8 +: 8] = 8'(img_a[i]);
    for (int i = 0; i < 9; i++) kv_a[i*8 +: 8] = 8'(ker_a[i]);
    relu_a = relu;
    en_a   = 1'b1;
    @(posedge clk); #1;
    exp_a = model_map(img_a, ker_a, A_IMG, 1, 1'b0, A_ACC, relu);
    for (int i = 0; i < A_N; i++) q_a.push_back('{i / A_OS, i % A_OS, exp_a[i]});
    check("a_busy_start", 64'(busy_a), 64'd1);
    check("a_fmap_cleared", 64'(|ofm_a), 64'd0);
    for (int i = 0; i < A_IMG * A_IMG; i++) ifm_a[i*8 +: 8] = 8'($urandom);
    for (int i = 0; i < 9; i++) kv_a[i*8 +: 8] = 8'($urandom);
    relu_a = 1'($urandom);
    for (int k = 1; k <= A_N; k++) begin
      @(posedge clk); #1;
      en_a = 1'($urandom);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero_a("a_abort");
        q_a.delete();
        en_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (k == A_N - 1) begin
        check("a_busy_before_last", 64'(busy_a), 64'd1);
        check("a_done_before_last", 64'(done_a), 64'd0);
      end
    end
    check("a_done_at_last", 64'(done_a), 64'd1);
    check("a_busy_at_last", 64'(busy_a), 64'd0);
    en_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("a_done_hold", 64'(done_a), 64'd1);
    check("a_busy_hold", 64'(busy_a), 64'd0);
    check("a_all_pixels_seen", 64'(q_a.size()), 64'd0);
    en_a = 1'b0;
    @(posedge clk); #1;
    check("a_done_clear", 64'(done_a), 64'd0);
    check("a_busy_idle", 64'(busy_a), 64'd0);
    for (int i = 0; i < A_N; i++)
      check($sformatf("a_fmap[%0d]", i), 64'(ofm_a[i*A_ACC +: A_ACC]), 64'(exp_a[i]));
  endtask

  task automatic run_b(input bit relu);
    for (int i = 0; i < B_IMG * B_IMG; i++) ifm_b[i*8 +: 8] = 8'(img_b[i]);
    for (int i = 0; i < 9; i++) kv_b[i*8 +: 8] = 8'(ker_b[i]);
    relu_b = relu;
    en_b   = 1'b1;
    @(posedge clk); #1;
    exp_b = model_map(img_b, ker_b, B_IMG, 2, 1'b1, B_ACC, relu);
    for (int i = 0; i < B_N; i++) q_b.push_back('{i / B_OS, i % B_OS, exp_b[i]});
    check("b_busy_start", 64'(busy_b), 64'd1);
    for (int i = 0; i < B_IMG * B_IMG; i++) ifm_b[i*8 +: 8] = 8'($urandom);
    relu_b = ~relu;
    for (int k = 1; k <= B_N; k++) begin
      @(posedge clk); #1;
      en_b = 1'($urandom);
      if (k == B_N - 1) check("b_done_before_last", 64'(done_b), 64'd0);
    end
    check("b_done_at_last", 64'(done_b), 64'd1);
    check("b_busy_at_last", 64'(busy_b), 64'd0);
    en_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("b_done_hold", 64'(done_b), 64'd1);
    check("b_all_pixels_seen", 64'(q_b.size()), 64'd0);
    en_b = 1'b0;
    @(posedge clk); #1;
    check("b_done_clear", 64'(done_b), 64'd0);
    for (int i = 0; i < B_N; i++)
      check($sformatf("b_fmap[%0d]", i), 64'(ofm_b[i*B_ACC +: B_ACC]), 64'(exp_b[i]));
  endtask

  task automatic fill_a(input int mode);
    img_a.delete();
    ker_a.delete();
    for (int i = 0; i < A_IMG * A_IMG; i++)
      case (mode)
        0:       img_a.push_back(((i / A_IMG) % 3 == 0) ? 1 : 0);
        1:       img_a.push_back(255);
        default: img_a.push_back(int'($urandom_range(0, 255)));
      endcase
    for (int i = 0; i < 9; i++)
      case (mode)
        0:       ker_a.push_back(i);
        1:       ker_a.push_back(255);
        default: ker_a.push_back(int'($urandom_range(0, 255)));
      endcase
  endtask

  task automatic fill_b(input int iv, input int kv);
    img_b.delete();
    ker_b.delete();
    for (int i = 0; i < B_IMG * B_IMG; i++)
      img_b.push_back(iv < 0 ? int'($urandom_range(0, 255)) : iv);
    for (int i = 0; i < 9; i++)
      ker_b.push_back(kv < 0 ? int'($urandom_range(0, 255)) : kv);
  endtask

  task automatic check_pattern0();
    check("a_dir_r0", 64'(ofm_a[(0*A_OS+5)*A_ACC +: A_ACC]), 64'd3);
    check("a_dir_r1", 64'(ofm_a[(1*A_OS+7)*A_ACC +: A_ACC]), 64'd21);
    check("a_dir_r2", 64'(ofm_a[(2*A_OS+0)*A_ACC +: A_ACC]), 64'd12);
    check("a_dir_r25", 64'(ofm_a[(25*A_OS+25)*A_ACC +: A_ACC]), 64'd21);
  endtask

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    relu_a = 1'b0;
    relu_b = 1'b0;
    ifm_a  = '1;
    ifm_b  = '1;
    kv_a   = '1;
    kv_b   = '1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_a("a_reset");
    check("b_reset_fmap", 64'(|ofm_b), 64'd0);
    check("b_reset_done", 64'(done_b), 64'd0);
    check("b_reset_busy", 64'(busy_b), 64'd0);
    en_a  = 1'b1;
    en_b  = 1'b1;
    #3;
    check("a_no_start_in_reset", 64'(busy_a), 64'd0);
    en_a  = 1'b0;
    en_b  = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    fill_a(0);
    run_a(1'b0, 0);
    check_pattern0();
    repeat (3) @(posedge clk);
    #1;
    check("a_idle_quiet", 64'(busy_a | done_a | valid_a), 64'd0);

    fill_a(1);
    run_a(1'b0, 0);
    check("a_max_sum", 64'(ofm_a[0 +: A_ACC]), 64'd585225);
    for (int n = 0; n < 2; n++) begin
      fill_a(2);
      run_a(1'($urandom), 0);
    end

    fill_a(0);
    run_a(1'b0, 100);
    check_zero_a("a_after_abort");
    run_a(1'b0, 0);
    check_pattern0();

    fill_b(1, 1);
    run_b(1'b0);
    check("b_stride_ones", 64'(ofm_b[4*B_ACC +: B_ACC]), 64'd9);
    fill_b(8'h7f, 8'hff);
    run_b(1'b0);
    check("b_neg_sum", 64'(ofm_b[0 +: B_ACC]), 64'h0b89);
    run_b(1'b1);
    check("b_relu", 64'(ofm_b[8*B_ACC +: B_ACC]), 64'd0);
    fill_b(8'h7f, 8'h7f);
    run_b(1'b0);
    check("b_sat_pos", 64'(ofm_b[0 +: B_ACC]), 64'h07ff);
    fill_b(8'h80, 8'h7f);
    run_b(1'b1);
    check("b_sat_neg_relu", 64'(ofm_b[0 +: B_ACC]), 64'd0);
    run_b(1'b0);
    check("b_sat_neg", 64'(ofm_b[0 +: B_ACC]), 64'h0800);
    for (int n = 0; n < 4; n++) begin
      fill_b(-1, -1);
      run_b(1'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    check("a_queue_empty", 64'(q_a.size()), 64'd0);
    check("b_queue_empty", 64'(q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
